debug_run_controller: RTL

Sequences the MIPS pipeline for the UART debugger. Host commands drive the pipeline clock enable: free-run, N-cycle step, halt, or pipeline reset. It stops automatically on program end or on a PC breakpoint. After every stop it requests one debug-bus dump and waits for the transmitter to finish before accepting new work. It sits between the UART command decoder and the pipeline / end-of-program detector / debug transmitter.

---
 rtl/debug_run_controller_pkg.sv | 28 ++
 rtl/debug_run_controller_if.sv | 13 +
 rtl/debug_run_controller_sat_counter.sv | 31 +++
 rtl/debug_run_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/debug_run_controller_pkg.sv
// Shared encodings for the debug run controller: FSM states, host command
// opcodes and halt causes.
package debug_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP      = 3'd2,
        ST_RESETTING = 3'd3,
        ST_DUMP_REQ  = 3'd4,
        ST_DUMP_WAIT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_HALT  = 2'b00,
        OP_RUN   = 2'b01,
        OP_STEP  = 2'b10,
        OP_RESET = 2'b11
    } cmd_op_t;

    typedef enum logic [1:0] {
        CAUSE_HOST_HALT   = 2'b00,
        CAUSE_STEP_DONE   = 2'b01,
        CAUSE_BREAKPOINT  = 2'b10,
        CAUSE_PROGRAM_END = 2'b11
    } halt_cause_t;

endpackage

// File: rtl/debug_run_controller_if.sv
// Host command handshake between the UART command decoder (master) and the
// debug run controller (slave).
interface debug_run_controller_if #(
    parameter int STEP_W = 16
) ();
    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic [STEP_W-1:0] cmd_arg;
    logic              cmd_ready;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/debug_run_controller_sat_counter.sv
// Up-counter with synchronous clear that sticks at its all-ones value
// instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1'b1);

    logic [WIDTH-1:0] count_r;

    // Counter register: clear wins over increment, increment stops at MAX_VAL
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= {WIDTH{1'b0}};
        end else if (inc && (count_r != MAX_VAL)) begin
            count_r <= count_r + ONE_VAL;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
endmodule

// File: rtl/debug_run_controller.sv
// Gates the pipeline clock enable for the UART debugger: run, N-step, halt and
// pipeline reset, with auto-stop on program end / breakpoint and a dump per stop.
module debug_run_controller
    import debug_ctrl_pkg::*;
#(
    parameter int PC_W       = 10,
    parameter int STEP_W     = 16,
    parameter int CYC_W      = 32,
    parameter int RST_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    debug_run_controller_if.slave cmd,
    input  logic              bp_enable,
    input  logic [PC_W-1:0]   bp_pc,
    input  logic [PC_W-1:0]   pc_ifid,
    input  logic              program_finished,
    output logic              pipe_clk_enable,
    output logic              pipe_reset,
    output logic              clear_program_finished,
    output logic              dump_req,
    input  logic              dump_done,
    output logic [CYC_W-1:0]  cycle_count,
    output logic [1:0]        halt_cause,
    output logic [2:0]        state
);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0]     RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1'b1);

    state_t            state_r;
    state_t            state_next_s;
    cmd_op_t           cmd_op_s;
    logic              cmd_ready_s;
    logic              cmd_fire_s;
    logic              idle_fire_s;
    logic              start_reset_s;
    logic              active_s;
    logic              bp_hit_s;
    logic              stop_s;
    halt_cause_t       cause_s;
    logic              enable_s;
    logic              pipe_reset_s;
    logic              clear_pf_s;
    logic              dump_req_s;
    logic [STEP_W-1:0] remaining_r;
    logic              first_cycle_r;
    halt_cause_t       halt_cause_r;
    logic [RW-1:0]     rst_cnt_r;

    assign cmd_op_s      = cmd_op_t'(cmd.cmd_op);
    assign cmd_ready_s   = (state_r == ST_IDLE) || (state_r == ST_RUN) || (state_r == ST_STEP);
    assign cmd_fire_s    = cmd.cmd_valid && cmd_ready_s;
    assign idle_fire_s   = (state_r == ST_IDLE) && cmd_fire_s;
    assign start_reset_s = idle_fire_s && (cmd_op_s == OP_RESET);
    assign active_s      = (state_r == ST_RUN) || (state_r == ST_STEP);
    // first_cycle_r masks the match so a run can resume from the breakpoint PC
    assign bp_hit_s      = bp_enable && (pc_ifid == bp_pc) && !first_cycle_r;

    // Prioritised stop decision while running or stepping
    always_comb begin
        stop_s  = 1'b0;
        cause_s = CAUSE_HOST_HALT;
        if (active_s) begin
            if (program_finished) begin
                stop_s  = 1'b1;
                cause_s = CAUSE_PROGRAM_END;
            end else if (bp_hit_s) begin
                stop_s  = 1'b1;
                cause_s = CAUSE_BREAKPOINT;
            end else if ((state_r == ST_STEP) && (remaining_r == {STEP_W{1'b0}})) begin
                stop_s  = 1'b1;
                cause_s = CAUSE_STEP_DONE;
            end else if (cmd_fire_s && (cmd_op_s == OP_HALT)) begin
                stop_s  = 1'b1;
                cause_s = CAUSE_HOST_HALT;
            end else begin
                stop_s  = 1'b0;
                cause_s = CAUSE_HOST_HALT;
            end
        end else begin
            stop_s  = 1'b0;
            cause_s = CAUSE_HOST_HALT;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (idle_fire_s) begin
                    case (cmd_op_s)
                        OP_RUN:   state_next_s = ST_RUN;
                        OP_STEP:  state_next_s = ST_STEP;
                        OP_RESET: state_next_s = ST_RESETTING;
                        default:  state_next_s = ST_IDLE;
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN, ST_STEP: begin
                if (stop_s) begin
                    state_next_s = ST_DUMP_REQ;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_RESETTING: begin
                if (rst_cnt_r == RST_LAST) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESETTING;
                end
            end
            ST_DUMP_REQ:  state_next_s = ST_DUMP_WAIT;
            ST_DUMP_WAIT: begin
                if (dump_done) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DUMP_WAIT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode; the enable must react in the same cycle as a stop
    always_comb begin
        enable_s     = 1'b0;
        pipe_reset_s = 1'b0;
        clear_pf_s   = 1'b0;
        dump_req_s   = 1'b0;
        case (state_r)
            ST_RUN, ST_STEP: enable_s = !stop_s;
            ST_RESETTING: begin
                enable_s     = 1'b1;
                pipe_reset_s = 1'b1;
                clear_pf_s   = (rst_cnt_r == {RW{1'b0}});
            end
            ST_DUMP_REQ: dump_req_s = 1'b1;
            default: begin
                enable_s   = 1'b0;
                dump_req_s = 1'b0;
            end
        endcase
    end

    // Step budget, resume mask, latched cause and reset-hold timer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remaining_r   <= {STEP_W{1'b0}};
            first_cycle_r <= 1'b0;
            halt_cause_r  <= CAUSE_HOST_HALT;
            rst_cnt_r     <= {RW{1'b0}};
        end else begin
            first_cycle_r <= idle_fire_s && ((cmd_op_s == OP_RUN) || (cmd_op_s == OP_STEP));

            if (idle_fire_s && (cmd_op_s == OP_STEP)) begin
                remaining_r <= (cmd.cmd_arg == {STEP_W{1'b0}}) ? STEP_ONE : cmd.cmd_arg;
            end else if (start_reset_s) begin
                remaining_r <= {STEP_W{1'b0}};
            end else if ((state_r == ST_STEP) && enable_s) begin
                remaining_r <= remaining_r - STEP_ONE;
            end else begin
                remaining_r <= remaining_r;
            end

            if (stop_s) begin
                halt_cause_r <= cause_s;
            end else if (start_reset_s) begin
                halt_cause_r <= CAUSE_HOST_HALT;
            end else begin
                halt_cause_r <= halt_cause_r;
            end

            if (start_reset_s) begin
                rst_cnt_r <= {RW{1'b0}};
            end else if (state_r == ST_RESETTING) begin
                rst_cnt_r <= rst_cnt_r + RW'(1'b1);
            end else begin
                rst_cnt_r <= rst_cnt_r;
            end
        end
    end

    sat_counter #(.WIDTH(CYC_W)) u_cycle_counter (
        .clock (clock),
        .reset (reset),
        .clr   (start_reset_s),
        .inc   (active_s && enable_s),
        .count (cycle_count)
    );

    assign cmd.cmd_ready          = cmd_ready_s;
    assign pipe_clk_enable        = enable_s;
    assign pipe_reset             = pipe_reset_s;
    assign clear_program_finished = clear_pf_s;
    assign dump_req               = dump_req_s;
    assign halt_cause             = halt_cause_r;
    assign state                  = state_r;
endmodule
